uart_axis_tx: RTL and testbench
===============================

Name: uart_axis_tx

Overview:
- UART transmitter with an AXI-Stream slave input. It is the transmit-side counterpart of the design's UART receiver.
- Words accepted on s_axis are buffered in a small internal FIFO, then serialized onto tx_wire. Each frame is: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Sits between an upstream stream producer and the board-level TX pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s. BIT_PERIOD = CLK_FREQ / BAUD_RATE (integer truncation), must be >= 2.
- DATA_WIDTH, 8, data bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits (1 or 2).
- FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  DATA_WIDTH  word to transmit.
- s_axis_tvalid  input  1  producer has a valid word.
- s_axis_tready  output  1  FIFO can accept a word.
- tx_wire  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is on the line.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words buffered, not counting the frame in flight.

Behaviour:
- Reset, sampled on clk only:
  - tx_wire=1, tx_busy=0, fifo_level=0, s_axis_tready=0 while rst is high.
  - FSM goes to IDLE; FIFO pointers and count clear; any frame in flight is abandoned, so tx_wire returns to 1 at the first edge with rst high.
- s_axis_tready = !rst_q && (fifo_level != FIFO_DEPTH), where rst_q is a register set during reset. tready rises one cycle after rst falls.
- Transfer occurs on an edge with tvalid && tready. tdata is written at the write pointer, and fifo_level increments unless a pop happens on the same edge.
- Simultaneous push and pop: level is unchanged; both pointers advance and wrap modulo FIFO_DEPTH.
- When full, tready=0. A pop on edge N makes tready=1 in the cycle after N.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_wire=1. If fifo_level!=0 on an edge: pop the head into shift register, clear baud_cnt, tx_wire<=0, go to START. First start-bit cycle is therefore one cycle after the push edge when the FIFO was empty.
  - START: hold 0 for BIT_PERIOD cycles, then drive bit 0 and go to DATA.
  - DATA: each bit is held exactly BIT_PERIOD cycles, LSB first. After bit DATA_WIDTH-1 completes, go to PARITY if PARITY!=0, else STOP.
  - PARITY: drive XOR of the data bits for even, inverted XOR for odd. Hold BIT_PERIOD cycles, then go to STOP.
  - STOP: drive 1 for STOP_BITS*BIT_PERIOD cycles. At the end, if fifo_level!=0, pop and drive the next start bit on the same edge (zero idle gap); otherwise go to IDLE.
- baud_cnt counts 0..BIT_PERIOD-1 and wraps; bit_cnt counts bits within DATA.
- Frame length = (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) * BIT_PERIOD cycles, exact, no jitter.
- tx_busy = (state != IDLE).
- tx_wire is registered (glitch-free) and changes only on bit boundaries.
- tvalid deasserting without a handshake has no effect. Data is captured only on a handshake.

Test Plan:
- CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_PERIOD=10), defaults, push 0xA5 into idle block -> tx_wire low for cycles 1..10 after the handshake, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles; tx_busy high for exactly 100 cycles; fifo_level returns to 0.
- Same config, push 0x01,0x02,0x03,0x04,0x05 back-to-back with tvalid held -> tready drops when level reaches 4; five frames on the line with no idle cycles between stop and start; all bytes received in order.
- PARITY=2, STOP_BITS=2, push 0x07 -> parity bit 1, two stop periods, frame length 120 cycles. With PARITY=1 the parity bit is 0.
- Assert rst for 1 cycle mid-DATA of 0x5A with 2 words queued -> tx_wire=1 and tx_busy=0 the next cycle; fifo_level=0; no further frames; tready=0 during reset, 1 one cycle after.
- With FIFO full, push and end-of-stop pop on the same edge -> level stays at 4, the new word is transmitted last, and no word is lost or duplicated.

Source files
------------

// File: rtl/uart_axis_tx.sv
// UART transmitter fed by an AXI-Stream slave port through a small FIFO.
// Frames: start bit, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stop bits.
module uart_axis_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          tx_wire,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int BCW        = $clog2(BIT_PERIOD);
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int LW         = PW + 1;
    localparam logic ODD      = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                  state_q, state_d;
    logic [BCW-1:0]          baud_q, baud_d;
    logic [3:0]              bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    pop;
    logic                    push;
    logic                    baud_end;
    logic                    rst_q;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           level_q;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   head;

    // A word moves on every rising edge where s_axis_tvalid && s_axis_tready;
    // tready depends only on registered state, never on tvalid.
    assign s_axis_tready = !rst_q && (level_q != LW'(FIFO_DEPTH));
    assign push          = s_axis_tvalid && s_axis_tready;
    assign head          = mem[rd_ptr];
    assign baud_end      = (baud_q == BCW'(BIT_PERIOD - 1));
    assign tx_wire       = tx_q;
    assign tx_busy       = (state_q != S_IDLE);
    assign fifo_level    = level_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + BCW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = (^head) ^ ODD;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 4'(DATA_WIDTH - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    bit_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // Back-to-back frames: next start bit begins on this same edge.
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = (^head) ^ ODD;
                            tx_d    = 1'b0;
                            state_d = S_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rst_q   <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_uart_axis_tx.sv
// Directed bench for uart_axis_tx: single frames, bursts, parity variants, reset abort, full FIFO.
module tb_uart_axis_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst_b;
    logic [7:0] tdata0, tdata1, tdata2;
    logic tvalid0, tvalid1, tvalid2;
    logic tready0, tready1, tready2;
    logic tx0, tx1, tx2;
    logic busy0, busy1, busy2;
    logic [2:0] lvl0, lvl1, lvl2;

    uart_axis_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut0 (
        .clk(clk), .rst(rst0), .s_axis_tdata(tdata0), .s_axis_tvalid(tvalid0),
        .s_axis_tready(tready0), .tx_wire(tx0), .tx_busy(busy0), .fifo_level(lvl0));
    uart_axis_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst_b), .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1),
        .s_axis_tready(tready1), .tx_wire(tx1), .tx_busy(busy1), .fifo_level(lvl1));
    uart_axis_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1)) dut2 (
        .clk(clk), .rst(rst_b), .s_axis_tdata(tdata2), .s_axis_tvalid(tvalid2),
        .s_axis_tready(tready2), .tx_wire(tx2), .tx_busy(busy2), .fifo_level(lvl2));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0: return tx0;
            1: return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0: return tready0;
            1: return tready1;
            default: return tready2;
        endcase
    endfunction

    function automatic logic [2:0] get_level(input int sel);
        case (sel)
            0: return lvl0;
            1: return lvl1;
            default: return lvl2;
        endcase
    endfunction

    task automatic set_in(input int sel, input logic [7:0] d, input logic v);
        case (sel)
            0: begin tdata0 = d; tvalid0 = v; end
            1: begin tdata1 = d; tvalid1 = v; end
            default: begin tdata2 = d; tvalid2 = v; end
        endcase
    endtask

    // Returns at #1 after the handshake edge; keep leaves tvalid asserted.
    task automatic push_word(input int sel, input logic [7:0] d, input bit keep);
        int n = 0;
        set_in(sel, d, 1'b1);
        while (!get_ready(sel) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("push_ready", get_ready(sel), 1);
        @(posedge clk); #1;
        if (!keep) set_in(sel, d, 1'b0);
    endtask

    // Called at #1 after the handshake edge of a word pushed into an idle block.
    task automatic check_frame(input int sel, input logic [15:0] bits, input int nbits, input string tag);
        int bad = 0;
        int busy_cnt = 0;
        logic busy_first = 1'b0;
        logic e;
        for (int k = 1; k <= nbits * 10 + 10; k++) begin
            @(posedge clk); #1;
            e = (k <= nbits * 10) ? bits[(k - 1) / 10] : 1'b1;
            if (get_tx(sel) !== e) bad++;
            if (get_busy(sel) === 1'b1) busy_cnt++;
            if (k == 1) busy_first = get_busy(sel);
        end
        check_val({tag, "_bit_errors"}, bad, 0);
        check_val({tag, "_busy_cycles"}, busy_cnt, nbits * 10);
        check_val({tag, "_busy_first"}, busy_first, 1);
        check_val({tag, "_busy_after"}, get_busy(sel), 0);
        check_val({tag, "_level_after"}, get_level(sel), 0);
    endtask

    // Line monitor for dut0 (10 clocks per bit, 8N1): decodes frames into rx_q.
    bit mon_active = 1'b0;
    int mon_pos    = 0;
    int mon_end    = 0;
    bit gap_chk    = 1'b0;
    bit have_prev  = 1'b0;
    logic [7:0] mon_byte;
    always begin
        @(posedge clk); #2;
        if (rst0 === 1'b1) begin
            mon_active = 1'b0;
            have_prev  = 1'b0;
        end else if (!mon_active) begin
            if (tx0 === 1'b0) begin
                mon_active = 1'b1;
                mon_pos    = 0;
                if (gap_chk && have_prev) check_val("idle_gap", cyc - mon_end - 1, 0);
            end
        end else begin
            mon_pos++;
        end
        if (mon_active && (mon_pos % 10 == 5)) begin
            if (mon_pos / 10 == 0) check_val("start_bit", tx0, 0);
            else if (mon_pos / 10 <= 8) mon_byte[mon_pos / 10 - 1] = tx0;
            else check_val("stop_bit", tx0, 1);
        end
        if (mon_active && mon_pos == 99) begin
            rx_q.push_back(mon_byte);
            mon_active = 1'b0;
            mon_end    = cyc;
            have_prev  = 1'b1;
        end
    end

    task automatic wait_rx(input int count, input string tag);
        int n = 0;
        while (rx_q.size() < count && n < 900) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, rx_q.size(), count);
    endtask

    task automatic compare_queues();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check_val($sformatf("rx_word_%0d", i), rx_q[i], exp_q[i]);
            else check_val($sformatf("rx_word_%0d_missing", i), 0, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        rst0 = 1'b1; rst_b = 1'b1;
        set_in(0, 8'h00, 1'b0);
        set_in(1, 8'h00, 1'b0);
        set_in(2, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tx", tx0, 1);
        check_val("rst_busy", busy0, 0);
        check_val("rst_level", lvl0, 0);
        check_val("rst_tready", tready0, 0);
        check_val("rst_tx_b", tx1, 1);
        rst0 = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        check_val("tready_after_rst", tready0, 1);

        // Single 8N1 frame of 0xA5
        exp_q.push_back(8'hA5);
        push_word(0, 8'hA5, 1'b0);
        check_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "a5");

        // Burst of five words with tvalid held
        gap_chk = 1'b1; have_prev = 1'b0;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        push_word(0, 8'h01, 1'b1);
        push_word(0, 8'h02, 1'b1);
        check_val("level_push_pop", lvl0, 1);
        push_word(0, 8'h03, 1'b1);
        push_word(0, 8'h04, 1'b1);
        push_word(0, 8'h05, 1'b0);
        check_val("full_level", lvl0, 4);
        check_val("full_tready", tready0, 0);
        wait_rx(6, "burst_count");
        gap_chk = 1'b0;
        compare_queues();
        repeat (5) @(posedge clk);
        #1;
        check_val("burst_idle_busy", busy0, 0);

        // Parity variants
        push_word(1, 8'h07, 1'b0);
        check_frame(1, {4'b0, 2'b11, 1'b1, 8'h07, 1'b0}, 12, "even2stop");
        push_word(2, 8'h07, 1'b0);
        check_frame(2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "odd");

        // Reset in the middle of a data bit with two words queued
        push_word(0, 8'h5A, 1'b1);
        push_word(0, 8'h77, 1'b1);
        push_word(0, 8'h88, 1'b0);
        check_val("queued_level", lvl0, 2);
        repeat (25) @(posedge clk);
        #1;
        check_val("mid_frame_busy", busy0, 1);
        rst0 = 1'b1;
        @(posedge clk); #1;
        check_val("abort_tx", tx0, 1);
        check_val("abort_busy", busy0, 0);
        check_val("abort_level", lvl0, 0);
        check_val("abort_tready", tready0, 0);
        rst0 = 1'b0;
        @(posedge clk); #1;
        check_val("abort_tready_rise", tready0, 1);
        low_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (tx0 !== 1'b1) low_cnt++;
        end
        check_val("abort_line_quiet", low_cnt, 0);
        check_val("abort_rx_count", rx_q.size(), 6);

        // Full FIFO; extra word waits for the end-of-stop pop
        for (int i = 8'h11; i <= 8'h16; i++) exp_q.push_back(8'(i));
        push_word(0, 8'h11, 1'b1);
        push_word(0, 8'h12, 1'b1);
        push_word(0, 8'h13, 1'b1);
        push_word(0, 8'h14, 1'b1);
        push_word(0, 8'h15, 1'b1);
        check_val("full2_level", lvl0, 4);
        check_val("full2_tready", tready0, 0);
        push_word(0, 8'h16, 1'b0);
        check_val("refill_level", lvl0, 4);
        check_val("refill_tready", tready0, 0);
        check_val("refill_busy", busy0, 1);
        wait_rx(12, "full_count");
        compare_queues();
        repeat (5) @(posedge clk);
        #1;
        check_val("final_level", lvl0, 0);
        check_val("final_busy", busy0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
